// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the streaming radix-2 SDF FFT stages.
// Helpers work at 64 bits; callers narrow results to their own widths.
package fft_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_BFLY,
      ST_DRAIN
   } state_t;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Round half up, then arithmetic shift right.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                      input int unsigned sh);
      if (sh == 0) return x;
      return (x + (64'sd1 <<< (sh - 1))) >>> sh;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                   input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic signed [63:0] bfly(input logic signed [63:0] a,
                                               input logic signed [63:0] b,
                                               input logic sub,
                                               input logic scale,
                                               input int unsigned w);
      logic signed [63:0] s;
      s = sub ? (a - b) : (a + b);
      if (scale) s = round_shift(s, 1);
      return saturate(s, w);
   endfunction

endpackage

// File: rtl/cmul_round.sv
// Combinational complex multiply by an optionally conjugated twiddle,
// rounded back to the data scale and saturated to DW bits.
module cmul_round
   import fft_pkg::*;
#(
   parameter int unsigned DW      = 22,
   parameter int unsigned TW      = 16,
   parameter int unsigned TW_FRAC = 14
) (
   input  logic signed [DW-1:0] a_real,
   input  logic signed [DW-1:0] a_imag,
   input  logic signed [TW-1:0] w_real,
   input  logic signed [TW-1:0] w_imag,
   input  logic                 conj,
   output logic signed [DW-1:0] y_real,
   output logic signed [DW-1:0] y_imag
);

   localparam int unsigned PW = DW + TW + 1;

   logic signed [PW-1:0] ar;
   logic signed [PW-1:0] ai;
   logic signed [PW-1:0] wr;
   logic signed [PW-1:0] wi;
   logic signed [PW-1:0] pr;
   logic signed [PW-1:0] pi;

   always_comb begin
      ar = PW'(a_real);
      ai = PW'(a_imag);
      wr = PW'(w_real);
      wi = conj ? -PW'(w_imag) : PW'(w_imag);
      pr = ar * wr - ai * wi;
      pi = ar * wi + ai * wr;
      y_real = DW'(saturate(round_shift(64'(pr), TW_FRAC), DW));
      y_imag = DW'(saturate(round_shift(64'(pi), TW_FRAC), DW));
   end

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: fill / butterfly / drain
// sequencing around a D-deep feedback memory and an external twiddle ROM.
module sdf_r2_stage
   import fft_pkg::*;
#(
   parameter  int unsigned DW      = 22,
   parameter  int unsigned TW      = 16,
   parameter  int unsigned TW_FRAC = 14,
   parameter  int unsigned DELAY   = 16,
   parameter  int unsigned SCALE   = 0,
   localparam int unsigned AW      = addr_width(DELAY)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inverse,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_real,
   input  logic signed [DW-1:0] in_imag,
   output logic [AW-1:0]        tw_addr,
   input  logic signed [TW-1:0] tw_real,
   input  logic signed [TW-1:0] tw_imag,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_real,
   output logic signed [DW-1:0] out_imag
);

   localparam logic [AW-1:0] K_LAST = AW'(DELAY - 1);

   state_t          state, state_n;
   logic [AW-1:0]   k, k_n, k_inc;
   logic            k_last;
   logic            pend, pend_n;
   logic            inv_frame, inv_frame_n;
   logic            inv_diff, inv_diff_n;

   logic [2*DW-1:0] mem [DELAY];
   logic            push;
   logic [2*DW-1:0] push_data;

   logic signed [DW-1:0] dl_real, dl_imag;
   logic signed [DW-1:0] sum_real, sum_imag;
   logic signed [DW-1:0] dif_real, dif_imag;
   logic signed [DW-1:0] twd_real, twd_imag;

   logic                 fill_accept;
   logic                 ov_n;
   logic signed [DW-1:0] or_n, oi_n;

   // Slot k is written in one half-block and read back at the same k in the next,
   // so a circular memory addressed directly by k behaves as a D-deep shift line.
   assign {dl_real, dl_imag} = mem[k];

   always_ff @(posedge clk) begin
      if (push) mem[k] <= push_data;
   end

   always_comb begin
      sum_real = DW'(bfly(64'(dl_real), 64'(in_real), 1'b0, SCALE != 0, DW));
      sum_imag = DW'(bfly(64'(dl_imag), 64'(in_imag), 1'b0, SCALE != 0, DW));
      dif_real = DW'(bfly(64'(dl_real), 64'(in_real), 1'b1, SCALE != 0, DW));
      dif_imag = DW'(bfly(64'(dl_imag), 64'(in_imag), 1'b1, SCALE != 0, DW));
   end

   cmul_round #(
      .DW      (DW),
      .TW      (TW),
      .TW_FRAC (TW_FRAC)
   ) u_cmul (
      .a_real (dl_real),
      .a_imag (dl_imag),
      .w_real (tw_real),
      .w_imag (tw_imag),
      .conj   (inv_diff),
      .y_real (twd_real),
      .y_imag (twd_imag)
   );

   always_comb begin
      tw_addr = '0;
      if (state == ST_FILL || state == ST_DRAIN) tw_addr = k;
   end

   always_comb begin
      state_n     = state;
      k_n         = k;
      pend_n      = pend;
      inv_frame_n = inv_frame;
      inv_diff_n  = inv_diff;
      push        = 1'b0;
      push_data   = '0;
      fill_accept = 1'b0;
      ov_n        = 1'b0;
      or_n        = out_real;
      oi_n        = out_imag;
      k_last      = (k == K_LAST);
      k_inc       = k_last ? '0 : k + AW'(1);

      case (state)
         ST_IDLE: begin
            if (in_valid) fill_accept = 1'b1;
         end
         ST_FILL: begin
            if (in_valid) fill_accept = 1'b1;
            else if (k == '0 && pend) state_n = ST_DRAIN;
         end
         ST_BFLY: begin
            if (in_valid) begin
               push      = 1'b1;
               push_data = {dif_real, dif_imag};
               ov_n      = 1'b1;
               or_n      = sum_real;
               oi_n      = sum_imag;
               k_n       = k_inc;
               if (k_last) begin
                  pend_n     = 1'b1;
                  inv_diff_n = inv_frame;
                  state_n    = ST_FILL;
               end
            end
         end
         ST_DRAIN: begin
            if (in_valid) begin
               fill_accept = 1'b1;
            end else begin
               push = 1'b1;
               ov_n = 1'b1;
               or_n = twd_real;
               oi_n = twd_imag;
               k_n  = k_inc;
               if (k_last) begin
                  pend_n  = 1'b0;
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // IDLE, FILL and an interrupted DRAIN all share the fill-sample action.
      if (fill_accept) begin
         push      = 1'b1;
         push_data = {in_real, in_imag};
         if (k == '0) inv_frame_n = inverse;
         if (pend) begin
            ov_n = 1'b1;
            or_n = twd_real;
            oi_n = twd_imag;
         end
         k_n = k_inc;
         if (k_last) begin
            pend_n  = 1'b0;
            state_n = ST_BFLY;
         end else begin
            state_n = ST_FILL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         k         <= '0;
         pend      <= 1'b0;
         inv_frame <= 1'b0;
         inv_diff  <= 1'b0;
         out_valid <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
      end else begin
         state     <= state_n;
         k         <= k_n;
         pend      <= pend_n;
         inv_frame <= inv_frame_n;
         inv_diff  <= inv_diff_n;
         out_valid <= ov_n;
         out_real  <= or_n;
         out_imag  <= oi_n;
      end
   end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed bench for sdf_r2_stage: D=16 with SCALE=0 and SCALE=1 instances
// sharing one input stream; outputs are collected and compared to hand values.
module tb_sdf_r2_stage;

   localparam int DW = 22;
   localparam int TW = 16;
   localparam int TF = 14;
   localparam int D  = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic inverse = 1'b0;
   logic in_valid = 1'b0;
   logic signed [DW-1:0] in_real = '0;
   logic signed [DW-1:0] in_imag = '0;

   logic [AW-1:0]        tw_addr0, tw_addr1;
   logic signed [TW-1:0] twr0, twi0, twr1, twi1;
   logic                 ov0, ov1;
   logic signed [DW-1:0] or0, oi0, or1, oi1;

   logic [2*DW-1:0] q0[$];
   logic [2*DW-1:0] q1[$];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Twiddle ROM: only k=1 carries a non-trivial value; all other k are unity.
   function automatic logic signed [TW-1:0] rom_r(input logic [AW-1:0] a);
      return (a == 4'd1) ? 16'sd16069 : 16'sd16384;
   endfunction
   function automatic logic signed [TW-1:0] rom_i(input logic [AW-1:0] a);
      return (a == 4'd1) ? -16'sd3196 : 16'sd0;
   endfunction

   always_comb begin
      twr0 = rom_r(tw_addr0);
      twi0 = rom_i(tw_addr0);
      twr1 = rom_r(tw_addr1);
      twi1 = rom_i(tw_addr1);
   end

   sdf_r2_stage #(.DW(DW), .TW(TW), .TW_FRAC(TF), .DELAY(D), .SCALE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .inverse(inverse), .in_valid(in_valid),
      .in_real(in_real), .in_imag(in_imag), .tw_addr(tw_addr0),
      .tw_real(twr0), .tw_imag(twi0), .out_valid(ov0),
      .out_real(or0), .out_imag(oi0)
   );

   sdf_r2_stage #(.DW(DW), .TW(TW), .TW_FRAC(TF), .DELAY(D), .SCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .inverse(inverse), .in_valid(in_valid),
      .in_real(in_real), .in_imag(in_imag), .tw_addr(tw_addr1),
      .tw_real(twr1), .tw_imag(twi1), .out_valid(ov1),
      .out_real(or1), .out_imag(oi1)
   );

   always @(negedge clk) begin
      if (ov0) q0.push_back({or0, oi0});
      if (ov1) q1.push_back({or1, oi1});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int sel, input int idx,
                          input int er, input int ei);
      logic [63:0] obs;
      logic [63:0] exp;
      logic [DW-1:0] r;
      logic [DW-1:0] i;
      r = DW'(er);
      i = DW'(ei);
      exp = 64'({r, i});
      obs = 'x;
      if (sel == 0 && idx < q0.size()) obs = 64'(q0[idx]);
      if (sel == 1 && idx < q1.size()) obs = 64'(q1[idx]);
      chk($sformatf("%s[%0d]", tag, idx), obs, exp);
   endtask

   task automatic drive(input logic v, input int r, input int i, input logic inv);
      in_valid = v;
      in_real  = DW'(r);
      in_imag  = DW'(i);
      inverse  = inv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) drive(1'b0, 0, 0, 1'b0);
   endtask

   task automatic clear_q();
      q0.delete();
      q1.delete();
   endtask

   initial begin
      // reset held with random inputs
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'($urandom);
         inverse  = 1'($urandom);
         in_real  = DW'($urandom);
         in_imag  = DW'($urandom);
         @(negedge clk);
         chk("reset_dut0", 64'({ov0, or0, oi0, tw_addr0}), 64'd0);
         chk("reset_dut1", 64'({ov1, or1, oi1, tw_addr1}), 64'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n = 1'b1;
      clear_q();
      idle(5);
      chk("idle_no_output", 64'(q0.size()), 64'd0);
      chk("idle_tw_addr", 64'(tw_addr0), 64'd0);

      // impulse
      clear_q();
      drive(1'b1, 1000, 0, 1'b0);
      for (int n = 1; n < 2 * D; n++) drive(1'b1, 0, 0, 1'b0);
      idle(40);
      chk("impulse_count", 64'(q0.size()), 64'd32);
      for (int n = 0; n < 2 * D; n++)
         chk_out("impulse", 0, n, (n == 0 || n == D) ? 1000 : 0, 0);
      chk("impulse_idle_tw_addr", 64'(tw_addr0), 64'd0);

      // DC frame
      clear_q();
      for (int n = 0; n < 2 * D; n++) drive(1'b1, 500, 0, 1'b0);
      idle(40);
      chk("dc_count", 64'(q0.size()), 64'd32);
      for (int n = 0; n < 2 * D; n++)
         chk_out("dc", 0, n, (n < D) ? 1000 : 0, 0);

      // positive full scale
      clear_q();
      for (int n = 0; n < 2 * D; n++) drive(1'b1, 2097151, 0, 1'b0);
      idle(40);
      chk_out("satpos_s0_sum", 0, 0, 2097151, 0);
      chk_out("satpos_s0_sum", 0, 15, 2097151, 0);
      chk_out("satpos_s0_dif", 0, 16, 0, 0);
      chk_out("satpos_s1_sum", 1, 0, 2097151, 0);
      chk_out("satpos_s1_dif", 1, 16, 0, 0);

      // negative full scale
      clear_q();
      for (int n = 0; n < 2 * D; n++) drive(1'b1, -2097152, 0, 1'b0);
      idle(40);
      chk_out("satneg_s0_sum", 0, 0, -2097152, 0);
      chk_out("satneg_s0_dif", 0, 16, 0, 0);
      chk_out("satneg_s1_sum", 1, 0, -2097152, 0);

      // twiddle, forward
      clear_q();
      for (int n = 0; n < 2 * D; n++) drive(1'b1, (n == 1) ? 1000 : 0, 0, 1'b0);
      idle(40);
      chk_out("twid_fwd_sum", 0, 1, 1000, 0);
      chk_out("twid_fwd_dif", 0, 17, 981, -195);

      // twiddle, inverse; inverse asserted only with the first sample
      clear_q();
      for (int n = 0; n < 2 * D; n++)
         drive(1'b1, (n == 1) ? 1000 : 0, 0, (n == 0) ? 1'b1 : 1'b0);
      idle(40);
      chk_out("twid_inv_sum", 0, 1, 1000, 0);
      chk_out("twid_inv_dif", 0, 17, 981, 195);

      // back-to-back frames with a 3-cycle stall in frame 2
      clear_q();
      for (int n = 0; n < D; n++) drive(1'b1, 10 * n, 0, 1'b0);
      for (int n = 0; n < D; n++) drive(1'b1, 5, 0, 1'b0);
      for (int n = 0; n < D; n++) drive(1'b1, 7, 0, 1'b0);
      for (int n = 0; n < D; n++) begin
         if (n == 5) idle(3);
         drive(1'b1, n, 0, 1'b0);
      end
      idle(40);
      chk("b2b_count", 64'(q0.size()), 64'd64);
      for (int n = 0; n < D; n++) begin
         chk_out("b2b_f1_sum", 0, n, 10 * n + 5, 0);
         if (n == 1) chk_out("b2b_f1_dif", 0, D + n, 5, -1);
         else        chk_out("b2b_f1_dif", 0, D + n, 10 * n - 5, 0);
         chk_out("b2b_f2_sum", 0, 2 * D + n, 7 + n, 0);
         if (n == 1) chk_out("b2b_f2_dif", 0, 3 * D + n, 6, -1);
         else        chk_out("b2b_f2_dif", 0, 3 * D + n, 7 - n, 0);
      end
      chk("b2b_idle_tw_addr", 64'(tw_addr0), 64'd0);

      // reset in the middle of a frame discards it
      for (int n = 0; n < 10; n++) drive(1'b1, 300, 0, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_out", 64'({ov0, or0, oi0, tw_addr0}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_q();
      idle(40);
      chk("midreset_no_output", 64'(q0.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
